cmem_mbox: RTL and testbench

Parametrised successor of the shared configuration memory / mailbox between the Raspberry Pi SPI side and the Amiga CP side. It holds a dual-ported register file in the clk200 domain. It implements two independent event/enable interrupt channels, R (Amiga→Pi, RASP_IRQ) and A (Pi→Amiga, AMI_INT2_n), with selectable IRQ signalling mode and a bounded INT2 assertion window. Register width, address space, block timeout and reset enables are generics, and both sides may write data registers.

---
 rtl/cmem_mbox.sv | 261 ++++++++++++++++++++++++++
 tb/tb_cmem_mbox.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmem_mbox.sv
// rtl/cmem_mbox.sv - shared config memory / mailbox between Pi SPI side and Amiga CP side
//
// Purpose:
//   Dual-ported register file in the clk200 domain. The top four addresses are
//   event/enable registers for two interrupt channels:
//     R channel (Amiga -> Pi)  : r_events / r_enable, drives RASP_IRQ
//     A channel (Pi -> Amiga)  : a_events / a_enable, drives AMI_INT2_n
//   The remaining addresses are plain data registers writable from both sides.
//
// Ports:
//   clk200           in   sole clock
//   reset            in   asynchronous, active-high
//   spi_read/write   in   Pi-side access strobes (one cycle per access)
//   spi_address      in   Pi-side address
//   spi_out_cmem_in  in   Pi-side write data
//   spi_in_cmem_out  out  Pi-side read data (1-cycle latency, held between reads)
//   cp_read/write    in   Amiga-side access strobes
//   cp_address       in   Amiga-side address
//   cp_out_cmem_in   in   Amiga-side write data
//   cp_in_cmem_out   out  Amiga-side read data (1-cycle latency, held between reads)
//   RASP_IRQ         out  interrupt to the Pi (toggle or level, see R_IRQ_LEVEL)
//   AMI_INT2_n       out  open-drain interrupt to the Amiga: 0 when driving, z otherwise
//   a_blocked        out  A channel is held off after a too-long INT2 assertion

module cmem_mbox #(
  parameter int          DATA_W       = 4,
  parameter int          ADDR_W       = 4,
  parameter int          R_IRQ_LEVEL  = 0,
  parameter int unsigned BLOCK_CYCLES = 32'd268435455,
  parameter int unsigned R_EN_RST     = 7,
  parameter int unsigned A_EN_RST     = 3
) (
  input  logic              clk200,
  input  logic              reset,
  input  logic              spi_read,
  input  logic              spi_write,
  input  logic [ADDR_W-1:0] spi_address,
  input  logic [DATA_W-1:0] spi_out_cmem_in,
  output logic [DATA_W-1:0] spi_in_cmem_out,
  input  logic              cp_read,
  input  logic              cp_write,
  input  logic [ADDR_W-1:0] cp_address,
  input  logic [DATA_W-1:0] cp_out_cmem_in,
  output logic [DATA_W-1:0] cp_in_cmem_out,
  output logic              RASP_IRQ,
  output wire               AMI_INT2_n,
  output logic              a_blocked
);

  localparam int NREG  = 2 ** ADDR_W;
  localparam int NDATA = NREG - 4;

  localparam logic [ADDR_W-1:0] A_REV = ADDR_W'(NREG - 4);
  localparam logic [ADDR_W-1:0] A_REN = ADDR_W'(NREG - 3);
  localparam logic [ADDR_W-1:0] A_AEV = ADDR_W'(NREG - 2);
  localparam logic [ADDR_W-1:0] A_AEN = ADDR_W'(NREG - 1);

  // Counter must hold BLOCK_CYCLES itself; a zero limit still needs one bit.
  localparam int CNT_W = (BLOCK_CYCLES == 0) ? 1 : $clog2(64'(BLOCK_CYCLES) + 64'd1);
  localparam logic [CNT_W-1:0] BC = CNT_W'(BLOCK_CYCLES);

  localparam logic [DATA_W-1:0] REN_INIT = DATA_W'(R_EN_RST);
  localparam logic [DATA_W-1:0] AEN_INIT = DATA_W'(A_EN_RST);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] r_mem [NDATA];
  logic [DATA_W-1:0] r_revents;
  logic [DATA_W-1:0] r_renable;
  logic [DATA_W-1:0] r_aevents;
  logic [DATA_W-1:0] r_aenable;
  logic [DATA_W-1:0] r_spi_rdata;
  logic [DATA_W-1:0] r_cp_rdata;
  logic              r_irq;
  logic              r_armed;
  logic              r_drive;
  logic              r_ablock;
  logic [CNT_W-1:0]  r_cnt;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic w_spi_rd_rev;
  logic w_spi_wr_ren;
  logic w_spi_wr_aev;
  logic w_cp_rd_aev;
  logic w_cp_wr_rev;
  logic w_cp_wr_aen;

  assign w_spi_rd_rev = spi_read  && (spi_address == A_REV);
  assign w_spi_wr_ren = spi_write && (spi_address == A_REN);
  assign w_spi_wr_aev = spi_write && (spi_address == A_AEV);
  assign w_cp_rd_aev  = cp_read   && (cp_address  == A_AEV);
  assign w_cp_wr_rev  = cp_write  && (cp_address  == A_REV);
  assign w_cp_wr_aen  = cp_write  && (cp_address  == A_AEN);

  // ---------------------------------------------------------------------------
  // Next-state values of the event/enable registers
  // ---------------------------------------------------------------------------
  // "_or" is the event value with the same-cycle producer write merged in but
  // before the consumer's clearing read; the consumer read returns this value.
  logic [DATA_W-1:0] w_rev_or;
  logic [DATA_W-1:0] w_rev_next;
  logic [DATA_W-1:0] w_ren_next;
  logic [DATA_W-1:0] w_aev_or;
  logic [DATA_W-1:0] w_aev_next;
  logic [DATA_W-1:0] w_aen_next;

  assign w_rev_or   = r_revents | (w_cp_wr_rev ? cp_out_cmem_in : '0);
  assign w_rev_next = w_spi_rd_rev ? '0 : w_rev_or;
  assign w_ren_next = w_spi_wr_ren ? spi_out_cmem_in : r_renable;

  assign w_aev_or   = r_aevents | (w_spi_wr_aev ? spi_out_cmem_in : '0);
  assign w_aev_next = w_cp_rd_aev ? '0 : w_aev_or;
  assign w_aen_next = w_cp_wr_aen ? cp_out_cmem_in : r_aenable;

  // ---------------------------------------------------------------------------
  // Trigger terms
  // ---------------------------------------------------------------------------
  logic             w_r_trig;
  logic             w_r_level;
  logic             w_a_trig;
  logic             w_drive_next;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_r_trig  = |(w_rev_or & w_ren_next);
  // Level mode looks at the post-clear value so the IRQ drops right after the read.
  assign w_r_level = |(w_rev_next & w_ren_next);
  assign w_a_trig  = |(w_aev_or & w_aen_next);

  // Uses the current block flag: the block takes effect one cycle after it sets.
  assign w_drive_next = w_a_trig && !r_ablock;
  assign w_cnt_inc    = (r_cnt == BC) ? r_cnt : r_cnt + CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Read views
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] w_spi_view;
  logic [DATA_W-1:0] w_cp_view;

  always_comb begin
    w_spi_view = '0;
    if (spi_address < A_REV) begin
      w_spi_view = r_mem[spi_address];
    end else if (spi_address == A_REV) begin
      w_spi_view = w_rev_or;
    end else if (spi_address == A_REN) begin
      w_spi_view = r_renable;
    end
  end

  always_comb begin
    w_cp_view = '0;
    if (cp_address < A_REV) begin
      w_cp_view = r_mem[cp_address];
    end else if (cp_address == A_AEV) begin
      w_cp_view = w_aev_or;
    end else if (cp_address == A_AEN) begin
      w_cp_view = r_aenable;
    end
  end

  // ---------------------------------------------------------------------------
  // Data registers (cp wins a same-address collision)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk200 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NDATA; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NDATA; i++) begin
        if (cp_write && (cp_address == ADDR_W'(i))) begin
          r_mem[i] <= cp_out_cmem_in;
        end else if (spi_write && (spi_address == ADDR_W'(i))) begin
          r_mem[i] <= spi_out_cmem_in;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Event / enable registers and read data
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk200 or posedge reset) begin
    if (reset) begin
      r_revents   <= '0;
      r_renable   <= REN_INIT;
      r_aevents   <= '0;
      r_aenable   <= AEN_INIT;
      r_spi_rdata <= '0;
      r_cp_rdata  <= '0;
    end else begin
      r_revents <= w_rev_next;
      r_renable <= w_ren_next;
      r_aevents <= w_aev_next;
      r_aenable <= w_aen_next;
      if (spi_read) begin
        r_spi_rdata <= w_spi_view;
      end
      if (cp_read) begin
        r_cp_rdata <= w_cp_view;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // R channel
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk200 or posedge reset) begin
    if (reset) begin
      r_irq   <= 1'b0;
      r_armed <= 1'b1;
    end else if (R_IRQ_LEVEL != 0) begin
      r_irq <= w_r_level;
    end else begin
      // A clearing read re-arms and suppresses any same-cycle toggle.
      if (w_spi_rd_rev) begin
        r_armed <= 1'b1;
      end else if (r_armed && w_r_trig) begin
        r_irq   <= ~r_irq;
        r_armed <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // A channel with assertion-window block
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk200 or posedge reset) begin
    if (reset) begin
      r_drive  <= 1'b0;
      r_ablock <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_drive <= w_drive_next;
      if (w_cp_rd_aev) begin
        r_cnt    <= '0;
        r_ablock <= 1'b0;
      end else if (w_drive_next) begin
        // Counting on the cycles INT2 is about to be driven makes the
        // low window exactly BLOCK_CYCLES long.
        r_cnt <= w_cnt_inc;
        if ((BLOCK_CYCLES != 0) && (w_cnt_inc == BC)) begin
          r_ablock <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign spi_in_cmem_out = r_spi_rdata;
  assign cp_in_cmem_out  = r_cp_rdata;
  assign RASP_IRQ        = r_irq;
  assign AMI_INT2_n      = r_drive ? 1'b0 : 1'bz;
  assign a_blocked       = r_ablock;

endmodule

// File: tb/tb_cmem_mbox.sv
// tb/tb_cmem_mbox.sv - self-checking bench for cmem_mbox (toggle and level instances)

module tb_cmem_mbox;

  localparam int BC = 8;
  localparam logic [3:0] A_REV = 4'd12;
  localparam logic [3:0] A_REN = 4'd13;
  localparam logic [3:0] A_AEV = 4'd14;
  localparam logic [3:0] A_AEN = 4'd15;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       spi_rd, spi_wr, cp_rd, cp_wr;
  logic [3:0] spi_a, spi_wd, cp_a, cp_wd;
  logic [3:0] spi_q0, cp_q0, spi_q1, cp_q1;
  logic       irq0, irq1, blk0, blk1;
  wire        ami0, ami1;

  pullup (ami0);
  pullup (ami1);

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cmem_mbox #(.DATA_W(4), .ADDR_W(4), .R_IRQ_LEVEL(0), .BLOCK_CYCLES(BC),
              .R_EN_RST(7), .A_EN_RST(3)) u_tog (
    .clk200(clk), .reset(rst),
    .spi_read(spi_rd), .spi_write(spi_wr), .spi_address(spi_a),
    .spi_out_cmem_in(spi_wd), .spi_in_cmem_out(spi_q0),
    .cp_read(cp_rd), .cp_write(cp_wr), .cp_address(cp_a),
    .cp_out_cmem_in(cp_wd), .cp_in_cmem_out(cp_q0),
    .RASP_IRQ(irq0), .AMI_INT2_n(ami0), .a_blocked(blk0)
  );

  cmem_mbox #(.DATA_W(4), .ADDR_W(4), .R_IRQ_LEVEL(1), .BLOCK_CYCLES(BC),
              .R_EN_RST(7), .A_EN_RST(3)) u_lvl (
    .clk200(clk), .reset(rst),
    .spi_read(spi_rd), .spi_write(spi_wr), .spi_address(spi_a),
    .spi_out_cmem_in(spi_wd), .spi_in_cmem_out(spi_q1),
    .cp_read(cp_rd), .cp_write(cp_wr), .cp_address(cp_a),
    .cp_out_cmem_in(cp_wd), .cp_in_cmem_out(cp_q1),
    .RASP_IRQ(irq1), .AMI_INT2_n(ami1), .a_blocked(blk1)
  );

  // ---------------------------------------------------------------------------
  // Behavioural model: mailbox contents plus channel state, updated per edge
  // ---------------------------------------------------------------------------
  logic [3:0] m_mem [16];
  logic [3:0] m_rev = 4'h0, m_ren = 4'h7, m_aev = 4'h0, m_aen = 4'h3;
  logic [3:0] m_spi_q = 4'h0, m_cp_q = 4'h0;
  bit         m_armed = 1'b1, m_irq_t = 1'b0, m_irq_l = 1'b0;
  bit         m_drive = 1'b0, m_block = 1'b0;
  int         m_cnt = 0;
  logic [3:0] t_rev_seen, t_aev_seen, t_ren, t_aen;
  bit         t_rd_rev, t_rd_aev, t_a_pending;

  initial for (int i = 0; i < 16; i++) m_mem[i] = 4'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) m_mem[i] = 4'h0;
      m_rev = 4'h0; m_ren = 4'h7; m_aev = 4'h0; m_aen = 4'h3;
      m_spi_q = 4'h0; m_cp_q = 4'h0;
      m_armed = 1'b1; m_irq_t = 1'b0; m_irq_l = 1'b0;
      m_drive = 1'b0; m_block = 1'b0; m_cnt = 0;
    end else begin
      // what each consumer sees: stored events plus the producer's same-cycle write
      t_rev_seen = m_rev | ((cp_wr && cp_a == A_REV) ? cp_wd : 4'h0);
      t_aev_seen = m_aev | ((spi_wr && spi_a == A_AEV) ? spi_wd : 4'h0);
      t_ren      = (spi_wr && spi_a == A_REN) ? spi_wd : m_ren;
      t_aen      = (cp_wr && cp_a == A_AEN) ? cp_wd : m_aen;
      t_rd_rev   = spi_rd && spi_a == A_REV;
      t_rd_aev   = cp_rd && cp_a == A_AEV;

      if (spi_rd)
        m_spi_q = (spi_a < A_REV) ? m_mem[spi_a] :
                  (spi_a == A_REV) ? t_rev_seen :
                  (spi_a == A_REN) ? m_ren : 4'h0;
      if (cp_rd)
        m_cp_q = (cp_a < A_REV) ? m_mem[cp_a] :
                 (cp_a == A_AEV) ? t_aev_seen :
                 (cp_a == A_AEN) ? m_aen : 4'h0;

      if (spi_wr && spi_a < A_REV) m_mem[spi_a] = spi_wd;
      if (cp_wr && cp_a < A_REV)   m_mem[cp_a]  = cp_wd;

      m_rev = t_rd_rev ? 4'h0 : t_rev_seen;
      m_aev = t_rd_aev ? 4'h0 : t_aev_seen;
      m_ren = t_ren;
      m_aen = t_aen;

      if (t_rd_rev) m_armed = 1'b1;
      else if (m_armed && ((t_rev_seen & t_ren) != 4'h0)) begin
        m_irq_t = !m_irq_t;
        m_armed = 1'b0;
      end
      m_irq_l = (m_rev & m_ren) != 4'h0;

      t_a_pending = (t_aev_seen & t_aen) != 4'h0;
      m_drive = t_a_pending && !m_block;
      if (t_rd_aev) begin
        m_cnt = 0;
        m_block = 1'b0;
      end else if (m_drive) begin
        if (m_cnt < BC) m_cnt++;
        if (m_cnt == BC) m_block = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every negedge, both instances against the model
  always @(negedge clk) begin
    chk("spi_rdata",     32'(spi_q0), 32'(m_spi_q));
    chk("cp_rdata",      32'(cp_q0),  32'(m_cp_q));
    chk("spi_rdata_lvl", 32'(spi_q1), 32'(m_spi_q));
    chk("cp_rdata_lvl",  32'(cp_q1),  32'(m_cp_q));
    chk("rasp_irq_tog",  32'(irq0),   32'(m_irq_t));
    chk("rasp_irq_lvl",  32'(irq1),   32'(m_irq_l));
    chk("int2_n",        32'(ami0),   32'(!m_drive));
    chk("int2_n_lvl",    32'(ami1),   32'(!m_drive));
    chk("a_blocked",     32'(blk0),   32'(m_block));
    chk("a_blocked_lvl", 32'(blk1),   32'(m_block));
  end

  task automatic idle();
    spi_rd = 1'b0; spi_wr = 1'b0; cp_rd = 1'b0; cp_wr = 1'b0;
  endtask

  task automatic drive(input bit srd, input bit swr, input logic [3:0] sa, input logic [3:0] sd,
                       input bit crd, input bit cwr, input logic [3:0] ca, input logic [3:0] cd);
    spi_rd = srd; spi_wr = swr; spi_a = sa; spi_wd = sd;
    cp_rd = crd; cp_wr = cwr; cp_a = ca; cp_wd = cd;
    @(posedge clk); #1;
    idle();
  endtask

  int low;

  initial begin
    idle();
    spi_a = 4'h0; spi_wd = 4'h0; cp_a = 4'h0; cp_wd = 4'h0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_int2_released", 32'(ami0), 1);
    chk("rst_rasp_irq", 32'(irq0), 0);
    chk("rst_a_blocked", 32'(blk0), 0);
    rst = 1'b0;

    // enable reset values
    drive(1'b1, 1'b0, A_REN, 4'h0, 1'b1, 1'b0, A_AEN, 4'h0);
    chk("r_enable_rst", 32'(spi_q0), 7);
    chk("a_enable_rst", 32'(cp_q0), 3);

    // toggle-mode arming
    drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, A_REV, 4'h1);
    chk("toggle_first", 32'(irq0), 1);
    drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, A_REV, 4'h2);
    chk("no_toggle_unarmed", 32'(irq0), 1);
    drive(1'b1, 1'b0, A_REV, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
    chk("r_events_read", 32'(spi_q0), 3);
    drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, A_REV, 4'h1);
    chk("toggle_rearmed", 32'(irq0), 0);
    chk("level_on", 32'(irq1), 1);

    // clearing read racing a producer write
    drive(1'b1, 1'b0, A_REV, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
    chk("r_events_read1", 32'(spi_q0), 1);
    chk("level_off", 32'(irq1), 0);
    drive(1'b1, 1'b0, A_REV, 4'h0, 1'b0, 1'b1, A_REV, 4'h4);
    chk("read_merge", 32'(spi_q0), 4);
    chk("level_stays_low", 32'(irq1), 0);
    chk("toggle_read_priority", 32'(irq0), 0);
    drive(1'b1, 1'b0, A_REV, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
    chk("r_events_cleared", 32'(spi_q0), 0);

    // A channel window
    drive(1'b0, 1'b1, A_AEV, 4'h1, 1'b0, 1'b0, 4'h0, 4'h0);
    low = 0;
    for (int i = 0; i < 20; i++) begin
      if (ami0 !== 1'b0) break;
      low++;
      @(posedge clk); #1;
    end
    chk("int2_low_cycles", 32'(low), 8);
    chk("blocked_set", 32'(blk0), 1);
    repeat (3) begin @(posedge clk); #1; end
    chk("int2_held_off", 32'(ami0), 1);
    drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, A_AEV, 4'h0);
    chk("a_events_read", 32'(cp_q0), 1);
    chk("blocked_cleared", 32'(blk0), 0);
    repeat (2) begin @(posedge clk); #1; end
    chk("int2_stays_released", 32'(ami0), 1);

    // data registers
    drive(1'b0, 1'b1, 4'd2, 4'h5, 1'b0, 1'b1, 4'd2, 4'hA);
    drive(1'b1, 1'b0, 4'd2, 4'h0, 1'b1, 1'b0, 4'd2, 4'h0);
    chk("collide_spi", 32'(spi_q0), 32'hA);
    chk("collide_cp", 32'(cp_q0), 32'hA);
    drive(1'b1, 1'b0, 4'd3, 4'h0, 1'b0, 1'b1, 4'd3, 4'h9);
    chk("rw_old_value", 32'(spi_q0), 0);
    drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'd3, 4'h0);
    chk("rw_new_value", 32'(cp_q0), 9);

    // unmapped views read 0
    drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, A_REV, 4'h3);
    drive(1'b1, 1'b0, A_AEN, 4'h0, 1'b1, 1'b0, A_REV, 4'h0);
    chk("spi_view_a_enable", 32'(spi_q0), 0);
    chk("cp_view_r_events", 32'(cp_q0), 0);

    // asynchronous reset mid-operation
    drive(1'b0, 1'b1, A_AEV, 4'h1, 1'b0, 1'b0, 4'h0, 4'h0);
    chk("int2_driving", 32'(ami0), 0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_int2", 32'(ami0), 1);
    chk("async_rst_irq", 32'(irq0), 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, A_REV, 4'h0, 1'b1, 1'b0, A_AEV, 4'h0);
    chk("r_events_after_rst", 32'(spi_q0), 0);
    chk("a_events_after_rst", 32'(cp_q0), 0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1);
  end

endmodule
